// File: rtl/fsm_oe4s_sequencer_if.sv
// Control/CSR-side bundle of the 4-state sequencer: program writes, run handshake,
// status pulses, kernel transition selects and the one-hot state mirror.
interface fsm_oe4s_sequencer_if #(
    parameter int CW = 8
);
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [1:0]    cfg_next;
    logic [CW-1:0] cfg_dwell;
    logic          cfg_last;
    logic          start;
    logic          stop;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [1:0]    t0x;
    logic [1:0]    t1x;
    logic [1:0]    t2x;
    logic [1:0]    t3x;
    logic          st0;
    logic          st1;
    logic          st2;
    logic          st3;

    modport master (
        output cfg_we, cfg_addr, cfg_next, cfg_dwell, cfg_last, start, stop,
        input  busy, done, cfg_err, t0x, t1x, t2x, t3x, st0, st1, st2, st3
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_next, cfg_dwell, cfg_last, start, stop,
        output busy, done, cfg_err, t0x, t1x, t2x, t3x, st0, st1, st2, st3
    );
endinterface

// File: rtl/fsm_oe4s_sequencer.sv
// Programmable sequencer for the 4-state one-hot FSM kernel: runs a 4-entry
// {next, dwell, last} program and mirrors the kernel state cycle for cycle.
module fsm_oe4s_sequencer #(
    parameter int CW = 8
) (
    input logic                  clk,
    input logic                  rst,
    fsm_oe4s_sequencer_if.slave  bus
);
    typedef enum logic {IDLE, RUN} ctrl_t;

    ctrl_t         state;
    logic [1:0]    cur;
    logic [1:0]    nxt;
    logic [CW-1:0] cnt;
    logic          busy_r;
    logic          done_r;
    logic          err_r;

    logic [1:0]    tbl_next  [4];
    logic [CW-1:0] tbl_dwell [4];
    logic [3:0]    tbl_last;

    // Mirror's next state for this cycle; stop beats step and completion.
    always_comb begin
        nxt = cur;
        if (state == RUN) begin
            if (bus.stop)
                nxt = 2'd0;
            else if (cnt == '0)
                nxt = tbl_last[cur] ? 2'd0 : tbl_next[cur];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur      <= 2'd0;
            cnt      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            tbl_last <= 4'b1000;
            for (int y = 0; y < 4; y++) begin
                tbl_next[y]  <= 2'(y + 1);
                tbl_dwell[y] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    // A write or a stop in the same cycle suppresses start.
                    if (bus.cfg_we) begin
                        tbl_next[bus.cfg_addr]  <= bus.cfg_next;
                        tbl_dwell[bus.cfg_addr] <= bus.cfg_dwell;
                        tbl_last[bus.cfg_addr]  <= bus.cfg_last;
                    end else if (bus.start && !bus.stop) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                        cur    <= 2'd0;
                        cnt    <= tbl_dwell[0];
                    end
                end
                RUN: begin
                    if (bus.cfg_we)
                        err_r <= 1'b1;
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        cur    <= 2'd0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (tbl_last[cur]) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        cur    <= 2'd0;
                    end else begin
                        cur <= tbl_next[cur];
                        cnt <= tbl_dwell[tbl_next[cur]];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.cfg_err = err_r;

    // Only the current state's select carries the move; the others hold themselves.
    assign bus.t0x = (cur == 2'd0) ? nxt : 2'd0;
    assign bus.t1x = (cur == 2'd1) ? nxt : 2'd1;
    assign bus.t2x = (cur == 2'd2) ? nxt : 2'd2;
    assign bus.t3x = (cur == 2'd3) ? nxt : 2'd3;

    assign bus.st0 = (cur == 2'd0);
    assign bus.st1 = (cur == 2'd1);
    assign bus.st2 = (cur == 2'd2);
    assign bus.st3 = (cur == 2'd3);
endmodule

// File: tb/tb_fsm_oe4s_sequencer.sv
// Directed bench for fsm_oe4s_sequencer: default program, custom program, stop,
// rejected writes, ignored start combinations and asynchronous reset mid-run.
module tb_fsm_oe4s_sequencer;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    fsm_oe4s_sequencer_if #(.CW(8)) bus ();

    fsm_oe4s_sequencer #(.CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int st_idx();
        case ({bus.st3, bus.st2, bus.st1, bus.st0})
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int tsel(input int y);
        case (y)
            0:       return int'(bus.t0x);
            1:       return int'(bus.t1x);
            2:       return int'(bus.t2x);
            default: return int'(bus.t3x);
        endcase
    endfunction

    task automatic wr(input int a, input int nx, input int dw, input int last);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 2'(a);
        bus.cfg_next  = 2'(nx);
        bus.cfg_dwell = 8'(dw);
        bus.cfg_last  = 1'(last);
        cyc();
        bus.cfg_we = 1'b0;
    endtask

    // Start from IDLE and follow the expected per-cycle state path to done.
    task automatic check_run(input string tag, input int p[$]);
        int expn;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int i = 0; i < p.size(); i++) begin
            chk($sformatf("%s_st%0d", tag, i), st_idx(), p[i]);
            chk($sformatf("%s_busy%0d", tag, i), int'(bus.busy), 1);
            expn = (i + 1 < p.size()) ? p[i + 1] : 0;
            for (int y = 0; y < 4; y++)
                chk($sformatf("%s_t%0dx_c%0d", tag, y, i), tsel(y), (y == p[i]) ? expn : y);
            cyc();
        end
        chk({tag, "_end_st"}, st_idx(), 0);
        chk({tag, "_end_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 1);
        cyc();
        chk({tag, "_done_clr"}, int'(bus.done), 0);
    endtask

    initial begin
        int p[$];
        n_chk  = 0;
        n_fail = 0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_next  = 2'd0;
        bus.cfg_dwell = 8'd0;
        bus.cfg_last  = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        rst = 1'b1;
        #12;
        chk("rst_st", st_idx(), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.cfg_err), 0);
        for (int y = 0; y < 4; y++)
            chk($sformatf("rst_t%0dx", y), tsel(y), y);
        rst = 1'b0;
        cyc();

        // Default program: S0..S3 one cycle each.
        p = '{0, 1, 2, 3};
        check_run("def", p);

        // Custom program: 0 -> 2 (dwell 3), 2 -> 1 (dwell 0), 1 terminal (dwell 1).
        wr(0, 2, 3, 0);
        wr(2, 1, 0, 0);
        wr(1, 3, 1, 1);
        p = '{0, 0, 0, 0, 2, 1, 1};
        check_run("prog", p);

        // Stop in the second cycle of the S0 dwell.
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("stop_c1_busy", int'(bus.busy), 1);
        cyc();
        bus.stop = 1'b1;
        #1;
        chk("stop_c2_t0x", int'(bus.t0x), 0);
        cyc();
        bus.stop = 1'b0;
        chk("stop_st", st_idx(), 0);
        chk("stop_busy", int'(bus.busy), 0);
        chk("stop_done", int'(bus.done), 0);
        check_run("after_stop", p);

        // Write to entry1 while running is rejected.
        bus.start = 1'b1;
        cyc();
        bus.start    = 1'b0;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 2'd1;
        bus.cfg_next = 2'd0;
        bus.cfg_dwell = 8'd7;
        bus.cfg_last = 1'b0;
        cyc();
        bus.cfg_we = 1'b0;
        chk("err_pulse", int'(bus.cfg_err), 1);
        cyc();
        chk("err_clr", int'(bus.cfg_err), 0);
        for (int k = 0; k < 20 && bus.busy; k++) cyc();
        chk("err_run_end", int'(bus.busy), 0);
        cyc();
        check_run("err_unchanged", p);

        // start+stop together in IDLE: no run.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("ss_busy", int'(bus.busy), 0);
        // start+write together: write wins, entry0 becomes terminal.
        bus.start = 1'b1;
        wr(0, 1, 0, 1);
        bus.start = 1'b0;
        chk("sw_busy", int'(bus.busy), 0);
        p = '{0};
        check_run("sw_write", p);

        // Asynchronous reset in the middle of a 6-cycle S2 dwell.
        wr(0, 2, 0, 0);
        wr(2, 3, 5, 0);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        cyc();
        chk("ar_pre_st", st_idx(), 2);
        rst = 1'b1;
        #1;
        chk("ar_st", st_idx(), 0);
        chk("ar_busy", int'(bus.busy), 0);
        chk("ar_done", int'(bus.done), 0);
        #1;
        rst = 1'b0;
        cyc();
        chk("ar_post_done", int'(bus.done), 0);
        p = '{0, 1, 2, 3};
        check_run("ar_def", p);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fsm_oe4s_sequencer.md
# fsm_oe4s_sequencer

Programmable sequencer for the 4-state one-hot universal FSM kernel. It holds a 4-entry transition program giving next state, dwell time and a terminal flag for each state, and runs it on a start/stop handshake. Its t0x..t3x outputs drive the kernel's transition-select inputs, and it keeps an internal state mirror, exported one-hot, that moves in lockstep with the kernel. It sits between a control/CSR master and the kernel, so software can change the kernel's behaviour without touching RTL.

## Interface
- CW, 8, dwell counter width; each state is held dwell+1 cycles.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  program-entry write strobe.
- cfg_addr  in  2  entry (state index) to write.
- cfg_next  in  2  next-state field for the entry.
- cfg_dwell  in  CW  dwell field for the entry.
- cfg_last  in  1  terminal flag; the program ends after this state's dwell.
- start  in  1  level-sampled run request.
- stop  in  1  level-sampled abort request.
- busy  out  1  high while the sequencer is running.
- done  out  1  one-cycle pulse on normal completion.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- t0x, t1x, t2x, t3x  out  2 each  transition selects for the kernel.
- st0, st1, st2, st3  out  1 each  one-hot mirror of the kernel state.

## Operation
- Program table: 4 entries of {next[1:0], dwell[CW-1:0], last}.
- Table reset contents: entry y = {next=(y+1) mod 4, dwell=0, last=(y==3)}.
- Control FSM has two states, IDLE and RUN. Reset puts it in IDLE with the mirror state at S0 and the dwell counter at 0.
- Reset output values: busy=0, done=0, cfg_err=0, st0=1, st1..st3=0, tyx=y for every y.
- Writes in IDLE commit on the clock edge. Writes in RUN are discarded, and cfg_err pulses in the next cycle.
- Start, IDLE with start=1, stop=0, cfg_we=0: go to RUN with the mirror at S0 and the counter loaded from entry0.dwell.
- RUN step with counter != 0: decrement the counter; state unchanged.
- RUN step with counter == 0 and entry[cur].last == 0: mirror moves to entry[cur].next, and the counter loads entry[next].dwell.
- RUN step with counter == 0 and entry[cur].last == 1: mirror moves to S0, FSM goes to IDLE, done=1 in the following cycle.
- A self-transition (next == cur) is legal; it reloads the counter.
- stop=1 in RUN: mirror moves to S0 and FSM goes to IDLE on the next edge, with no done. stop has priority over a same-cycle step or completion.
- Ignored inputs: start in RUN; stop in IDLE; start with stop or cfg_we in the same IDLE cycle (stop and write take priority).
- Transition selects, combinational from registered state: t[cur]x = the mirror's next state for this cycle; t[y]x = y for every y != cur.
- The kernel and the mirror must therefore agree every cycle when both are reset together.
- st0..st3 are decoded from the registered mirror state and are always exactly one-hot.

## Timing
- Start latency is 1 cycle: start sampled at edge E0 gives busy=1 and RUN in S0 after E0.
- Residency is entry.dwell+1 cycles per visited state.
- Total busy cycles equal the sum of (dwell+1) over the visited path.
- busy falls on the same edge as the final S0 transition. done is high for exactly the first IDLE cycle after completion.
- After completion or stop, a new start is accepted in the first IDLE cycle.
- Async reset mid-run: all outputs take their reset values immediately, the table returns to its reset contents, and no done is produced.
- The counter never wraps; it loads only on start or on a transition.

## Test plan
- Reset defaults, start at E0: mirror S0,S1,S2,S3 one cycle each; busy high for 4 cycles; S0 and done=1 in cycle 5; t0x=1 in the S0 RUN cycle.
- Program {0:next2,dwell3; 2:next1,dwell0; 1:last,dwell1}, then start: S0 for 4 cycles, S2 for 1, S1 for 2, then done; S3 never asserted.
- Stop in the 2nd cycle of a 4-cycle S0 dwell: S0 and busy=0 the next cycle, done stays 0; start one cycle later runs the program from S0.
- cfg_we on entry1 while busy: cfg_err pulses once, and a later run shows entry1 unchanged.
- Same-cycle start+stop, and same-cycle start+cfg_we, in IDLE: no run begins; the write takes effect, shown by a following start.
- Assert rst in the middle of S2 with dwell 5: immediate st0=1, busy=0, done=0; a subsequent start replays the default 4-cycle sequence.
